// File: rtl/coeff_loader_pkg.sv
// Shared definitions for the serial memory loaders (coefficient loader and
// the data loader that reuses the same framing).
//   - default word width, address width and words-per-load
//   - receive FSM state encoding
package coeff_loader_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned ADDR_W_DEF    = 9;
  localparam int unsigned NUM_COEFF_DEF = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_SHIFT,
    ST_DONE
  } load_state_t;

endpackage

// File: rtl/coeff_loader_serial_deser.sv
// serial_deser: MSB-first framed serial-to-parallel converter.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : receiver active; when low the bit counter is held at 0
//   frame       : marks the MSB of a word
//   sin         : serial data bit
//   last_bit    : combinational, the current cycle samples the LSB
//   word_valid  : one-cycle pulse after the LSB edge, word is valid with it
//   word        : assembled word (held until the next complete word)
//   error       : one-cycle pulse when frame arrives mid-word
module serial_deser #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame,
  input  logic              sin,
  output logic              last_bit,
  output logic              word_valid,
  output logic [DATA_W-1:0] word,
  output logic              error
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;  // 0: no word in progress, else bits received

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      error      <= 1'b0;
      if (!enable) begin
        bit_cnt <= '0;
      end else if (frame) begin
        // A frame always starts a new word; any partial word is dropped.
        shreg   <= {shreg[DATA_W-2:0], sin};
        bit_cnt <= CNT_W'(1);
        error   <= (bit_cnt != '0);
      end else if (bit_cnt != '0) begin
        shreg <= {shreg[DATA_W-2:0], sin};
        if (last_bit) begin
          word       <= {shreg[DATA_W-2:0], sin};
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// coeff_loader: receives NUM_COEFF framed serial words and writes them to
// COEFF_MEM at consecutive addresses, one registered write strobe per word.
// Ports:
//   Dclk, Reset_n   : serial clock, synchronous active-low reset
//   loadStart       : start a new load (ignored while busy)
//   Frame, serialIn : framed MSB-first serial input
//   coeffWriteAddr  : write address, loaded one cycle before the strobe
//   coeffDataIn     : write data, loaded one cycle before the strobe
//   writeEnable     : one-cycle write strobe
//   busy            : load in progress
//   loadDone        : all words written; held until next loadStart
//   frameError      : sticky, Frame seen mid-word during this load
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned NUM_COEFF = NUM_COEFF_DEF
) (
  input  logic              Dclk,
  input  logic              Reset_n,
  input  logic              loadStart,
  input  logic              Frame,
  input  logic              serialIn,
  output logic [ADDR_W-1:0] coeffWriteAddr,
  output logic [DATA_W-1:0] coeffDataIn,
  output logic              writeEnable,
  output logic              busy,
  output logic              loadDone,
  output logic              frameError
);

  localparam int unsigned CNT_W = $clog2(NUM_COEFF + 1);

  load_state_t       state;
  logic [CNT_W-1:0]  word_cnt;
  logic              we_arm;
  logic              rx_enable;
  logic              rx_last_bit;
  logic              rx_word_valid;
  logic              rx_error;
  logic [DATA_W-1:0] rx_word;

  assign rx_enable = (state == ST_WAIT_FRAME) || (state == ST_SHIFT);

  serial_deser #(
    .DATA_W(DATA_W)
  ) u_deser (
    .clk       (Dclk),
    .rst_n     (Reset_n),
    .enable    (rx_enable),
    .frame     (Frame),
    .sin       (serialIn),
    .last_bit  (rx_last_bit),
    .word_valid(rx_word_valid),
    .word      (rx_word),
    .error     (rx_error)
  );

  always_ff @(posedge Dclk) begin
    if (!Reset_n) begin
      state          <= ST_IDLE;
      word_cnt       <= '0;
      we_arm         <= 1'b0;
      coeffWriteAddr <= '0;
      coeffDataIn    <= '0;
      writeEnable    <= 1'b0;
      busy           <= 1'b0;
      loadDone       <= 1'b0;
      frameError     <= 1'b0;
    end else begin
      // Write sequencer: load data/address, strobe next cycle, drop after.
      writeEnable <= we_arm;
      we_arm      <= 1'b0;
      if (rx_word_valid && busy) begin
        coeffDataIn    <= rx_word;
        coeffWriteAddr <= word_cnt[ADDR_W-1:0];
        we_arm         <= 1'b1;
      end

      if (rx_error) frameError <= 1'b1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (loadStart) begin
            loadDone   <= 1'b0;
            frameError <= 1'b0;
            word_cnt   <= '0;
            busy       <= 1'b1;
            state      <= ST_WAIT_FRAME;
          end
        end
        ST_WAIT_FRAME: if (Frame) state <= ST_SHIFT;
        ST_SHIFT:      if (rx_last_bit && !Frame) state <= ST_WAIT_FRAME;
        default:       state <= ST_IDLE;
      endcase

      // Strobe falling: advance the word count; the final word ends the
      // load and overrides the receive state.
      if (writeEnable) begin
        word_cnt <= word_cnt + CNT_W'(1);
        if (word_cnt == CNT_W'(NUM_COEFF - 1)) begin
          loadDone <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader with a word-level reference model.
module tb_coeff_loader;

  localparam int NC = 512;

  logic        Dclk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        loadStart = 1'b0;
  logic        Frame = 1'b0;
  logic        serialIn = 1'b0;
  logic [8:0]  coeffWriteAddr;
  logic [15:0] coeffDataIn;
  logic        writeEnable;
  logic        busy;
  logic        loadDone;
  logic        frameError;

  coeff_loader #(
    .DATA_W   (16),
    .ADDR_W   (9),
    .NUM_COEFF(NC)
  ) dut (
    .Dclk          (Dclk),
    .Reset_n       (Reset_n),
    .loadStart     (loadStart),
    .Frame         (Frame),
    .serialIn      (serialIn),
    .coeffWriteAddr(coeffWriteAddr),
    .coeffDataIn   (coeffDataIn),
    .writeEnable   (writeEnable),
    .busy          (busy),
    .loadDone      (loadDone),
    .frameError    (frameError)
  );

  always #5 Dclk = ~Dclk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit  m_busy = 1'b0;
  bit  m_done = 1'b0;
  bit  m_err  = 1'b0;
  int  m_cnt  = 0;
  int  pulses = 0;
  logic we_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Dclk);
    #1;
  endtask

  task automatic idle(input int n);
    Frame = 1'b0;
    repeat (n) tick();
  endtask

  task automatic model_load_start();
    if (!m_busy) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
    end
  endtask

  task automatic model_word(input logic [15:0] d);
    if (m_busy) begin
      exp_q.push_back('{m_cnt, d});
      m_cnt++;
      if (m_cnt == NC) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic pulse_load_start();
    loadStart = 1'b1;
    model_load_start();
    tick();
    loadStart = 1'b0;
  endtask

  // Sends bits 15..(16-stop_at) of d, Frame on the first; optional loadStart
  // request coinciding with bit index ls_bit.
  task automatic send_word(input logic [15:0] d, input int stop_at = 16, input int ls_bit = -1);
    for (int b = 0; b < stop_at; b++) begin
      Frame    = (b == 0);
      serialIn = d[15-b];
      if (b == ls_bit) begin
        loadStart = 1'b1;
        model_load_start();
      end
      tick();
      loadStart = 1'b0;
    end
    Frame = 1'b0;
    if (stop_at == 16) model_word(d);
    else if (m_busy) m_err = 1'b1;
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge Dclk) begin
    wr_t e;
    if (writeEnable === 1'b1) begin
      pulses++;
      check("we_single_cycle", {31'b0, we_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'b0, writeEnable}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", {23'b0, coeffWriteAddr}, e.addr);
        check("we_data", {16'b0, coeffDataIn}, {16'b0, e.data});
      end
    end
    we_prev = writeEnable;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {23'b0, coeffWriteAddr}, 32'd0);
    check({tag, "_data"}, {16'b0, coeffDataIn}, 32'd0);
    check({tag, "_we"},   {31'b0, writeEnable}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, loadDone}, 32'd0);
    check({tag, "_ferr"}, {31'b0, frameError}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int          p0;

    // Reset, then idle with stray frames: nothing must be written.
    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    check_all_zero("reset");
    send_word(16'(($urandom)));
    send_word(16'(($urandom)));
    idle(4);
    check_all_zero("idle_frames");
    check("idle_no_we", pulses, 32'd0);

    // First word with cycle-exact write timing.
    pulse_load_start();
    check("start_busy", {31'b0, busy}, {31'b0, m_busy});
    check("start_done", {31'b0, loadDone}, 32'd0);
    w = 16'hA5C3;
    for (int b = 0; b < 16; b++) begin
      Frame    = (b == 0);
      serialIn = w[15-b];
      tick();
    end
    Frame = 1'b0;
    model_word(w);
    tick();
    check("c16_data", {16'b0, coeffDataIn}, 32'h0000A5C3);
    check("c16_addr", {23'b0, coeffWriteAddr}, 32'd0);
    check("c16_we", {31'b0, writeEnable}, 32'd0);
    tick();
    check("c17_we", {31'b0, writeEnable}, 32'd1);
    tick();
    check("c18_we", {31'b0, writeEnable}, 32'd0);
    check("c18_data", {16'b0, coeffDataIn}, 32'h0000A5C3);
    check("c18_addr", {23'b0, coeffWriteAddr}, 32'd0);

    // Rest of the load: random words with random gaps.
    for (int i = 1; i < NC; i++) begin
      send_word(16'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    check("load1_done", {31'b0, loadDone}, {31'b0, m_done});
    check("load1_busy", {31'b0, busy}, 32'd0);
    check("load1_pulses", pulses, NC);
    check("load1_drained", exp_q.size(), 32'd0);
    check("load1_last_addr", {23'b0, coeffWriteAddr}, NC - 1);

    // Back-to-back load, with an ignored loadStart mid-load.
    pulse_load_start();
    check("load2_done_clr", {31'b0, loadDone}, 32'd0);
    for (int i = 0; i < NC; i++)
      send_word(16'(i) ^ 16'h5A5A, 16, (i == 200) ? 5 : -1);
    idle(4);
    check("load2_done", {31'b0, loadDone}, {31'b0, m_done});
    check("load2_busy", {31'b0, busy}, 32'd0);
    check("load2_pulses", pulses, 2 * NC);
    check("load2_drained", exp_q.size(), 32'd0);
    check("load2_last_data", {16'b0, coeffDataIn}, {16'b0, 16'(NC - 1) ^ 16'h5A5A});

    // Frame mid-word on word 3.
    pulse_load_start();
    for (int i = 0; i < 3; i++) send_word(16'($urandom));
    send_word(16'($urandom), 7);
    w = 16'($urandom);
    send_word(w);
    idle(4);
    check("ferr_set", {31'b0, frameError}, {31'b0, m_err});
    check("ferr_addr", {23'b0, coeffWriteAddr}, 32'd3);
    check("ferr_data", {16'b0, coeffDataIn}, {16'b0, w});
    check("ferr_busy", {31'b0, busy}, 32'd1);

    // Continue up to word 100, then reset after its strobe.
    for (int i = 4; i <= 100; i++) send_word(16'($urandom));
    idle(3);
    check("pre_reset_drained", exp_q.size(), 32'd0);
    check("pre_reset_addr", {23'b0, coeffWriteAddr}, 32'd100);
    Reset_n = 1'b0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    repeat (2) tick();
    check_all_zero("mid_reset");
    Reset_n = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 3; i++) send_word(16'($urandom));
    idle(4);
    check("post_reset_no_we", pulses, p0);
    check_all_zero("post_reset");

    // Fresh load restarts at address 0.
    pulse_load_start();
    w = 16'($urandom);
    send_word(w);
    idle(4);
    check("restart_addr", {23'b0, coeffWriteAddr}, 32'd0);
    check("restart_data", {16'b0, coeffDataIn}, {16'b0, w});
    check("restart_pulse", pulses, p0 + 1);
    check("restart_busy", {31'b0, busy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
Serial-to-parallel writer for the coefficient memory write port. It receives MSB-first 16-bit coefficient words framed on a serial line and deserializes them. It drives the write address, the write data and a single write-enable pulse into COEFF_MEM for each word. It sits between the serial input pins and COEFF_MEM, and hands control to the main controller once NUM_COEFF words are stored.

Parameters:
DATA_W, 16, coefficient word width in bits
ADDR_W, 9, coefficient write address width
NUM_COEFF, 512, words per load; must be at most 2**ADDR_W

Ports:
Dclk  input  1  serial data clock; all logic on its rising edge
Reset_n  input  1  synchronous, active-low reset
loadStart  input  1  one-cycle request to begin a new coefficient load
Frame  input  1  high for one cycle, coincident with the MSB of each word
serialIn  input  1  serial coefficient bit, sampled each Dclk
coeffWriteAddr  output  ADDR_W  write address to COEFF_MEM
coeffDataIn  output  DATA_W  write data to COEFF_MEM
writeEnable  output  1  write strobe; COEFF_MEM captures on its rising edge
busy  output  1  high from loadStart acceptance until loadDone
loadDone  output  1  high after the final word's write pulse; held until next loadStart or reset
frameError  output  1  sticky; set on a Frame mid-word; cleared by loadStart or reset

Behaviour:
- Reset (Reset_n low at a rising edge): all outputs 0, bit counter 0, word counter 0, state IDLE.
- Reset asserted mid-load aborts the load. No further writeEnable pulses occur, and already-written memory contents are left as they are.
- Receive FSM states: IDLE, WAIT_FRAME, SHIFT, DONE.
- IDLE: Frame and serialIn are ignored. When loadStart is seen, clear loadDone, frameError and the word counter, set busy, and go to WAIT_FRAME.
- WAIT_FRAME: on Frame=1, shift serialIn in as the MSB, set the bit counter to 1, and go to SHIFT.
- SHIFT: shift one bit per cycle, MSB first.
  - When bit DATA_W-1 (the LSB) is sampled, hand the assembled word to the write sequencer and return to WAIT_FRAME.
  - A new Frame may arrive on the very next cycle, so back-to-back words must be supported with no gap.
- Frame during SHIFT before the LSB:
  - Set frameError.
  - Discard the partial word.
  - Treat the current bit as the MSB of a new word (bit counter = 1).
  - The word counter is not advanced.
- Write sequencer runs in parallel with the receive FSM. Counting cycles with the Frame cycle as cycle 0:
  - Cycle 16 (the edge after the LSB sample): coeffDataIn and coeffWriteAddr are loaded; writeEnable stays 0. This gives one full cycle of setup.
  - Cycle 17: writeEnable = 1.
  - Cycle 18: writeEnable = 0. Data and address are held unchanged through this cycle.
  - The address register increments when writeEnable falls. coeffWriteAddr holds its value until the next word is loaded.
- Word count:
  - After the write pulse for word NUM_COEFF-1: assert loadDone, deassert busy, go to DONE.
  - DONE behaves like IDLE: it waits for loadStart and ignores Frame.
- loadStart while busy is ignored.
- Address wrap cannot occur because a load ends at NUM_COEFF.
- writeEnable is a registered output and never glitches.

Decomposition:
- Shared package:
  - FSM state encoding.
  - DATA_W, ADDR_W and NUM_COEFF defaults.
  - These are shared with the future data loader, which writes the input/R memories using the same framing.
- Natural sub-module: serial_deser.
  - Contains the shift register, the bit counter and the Frame-mid-word detection.
  - Outputs: wordValid pulse, word, error pulse.
  - It is reusable by the data-input loader.

Test Plan:
- Reset_n low for 3 cycles, then high with no loadStart -> all outputs 0; Frame pulses produce no writeEnable.
- loadStart, then Frame plus bits of 0xA5C3 -> coeffDataIn=0xA5C3 and addr=0 at cycle 16; writeEnable high only at cycle 17.
- 512 back-to-back words with word i = i^0x5A5A, no inter-word gap -> exactly 512 writeEnable pulses at addr 0..511 with matching data; loadDone=1 and busy=0 after the last pulse.
- Frame reasserted at bit 7 of word 3 -> frameError=1; partial word dropped; the following word is written to addr 3.
- Reset_n low after word 100's pulse -> outputs return to 0, no further pulses; a new loadStart then restarts at addr 0.
- loadStart during a load -> ignored: addressing continues, and loadDone still asserts once after 512 words.
